// File: rtl/rv_pkg.sv
// Shared RV32I decode constants and the decoded-instruction payload carried by the ID register.
package rv_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [3:0] ALU_ADD_SUB = 4'b0000;
    localparam logic [3:0] ALU_SLL     = 4'b0001;
    localparam logic [3:0] ALU_SLT     = 4'b0010;
    localparam logic [3:0] ALU_SLTU    = 4'b0011;
    localparam logic [3:0] ALU_XOR     = 4'b0100;
    localparam logic [3:0] ALU_SRL_SRA = 4'b0101;
    localparam logic [3:0] ALU_OR      = 4'b0110;
    localparam logic [3:0] ALU_AND     = 4'b0111;
    localparam logic [3:0] ALU_AUIPC   = 4'b1010;
    localparam logic [3:0] ALU_LUI     = 4'b1011;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef struct packed {
        logic [3:0]      alu_op;
        logic            use_imm;
        logic            op_choice;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic            reg_write;
        logic            is_load;
        logic            is_store;
        logic            is_branch;
        logic            is_jump;
        logic            illegal;
    } decoded_t;

endpackage

// File: rtl/imm_gen.sv
// Immediate extraction and sign extension for the I/S/B/U/J formats, selected by opcode.
module imm_gen
    import rv_pkg::*;
(
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm
);

    always_comb begin
        imm = '0;
        case (instr[6:0])
            OPC_OP_IMM, OPC_JALR, OPC_LOAD:
                imm = {{20{instr[31]}}, instr[31:20]};
            OPC_STORE:
                imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            OPC_BRANCH:
                imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC:
                imm = {instr[31:12], 12'b0};
            OPC_JAL:
                imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default:
                imm = '0;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: decodes instr into ALU controls and holds it in a one-entry
// valid/ready pipeline register with load-use bubble insertion and flush.
module decode_stage
    import rv_pkg::*;
#(
    parameter int unsigned XLEN_P = XLEN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_valid,
    output logic              if_ready,
    input  logic [31:0]       instr,
    input  logic [XLEN_P-1:0] if_pc,
    input  logic              flush,
    input  logic              ex_ready,
    output logic              id_valid,
    output logic [3:0]        alu_op,
    output logic              use_imm,
    output logic              op_choice,
    output logic [XLEN_P-1:0] imm,
    output logic [XLEN_P-1:0] pc,
    output logic [4:0]        rs1,
    output logic [4:0]        rs2,
    output logic [4:0]        rd,
    output logic              reg_write,
    output logic              is_load,
    output logic              is_store,
    output logic              is_branch,
    output logic              is_jump,
    output logic              illegal
);

    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [XLEN-1:0]   imm_c;
    decoded_t          dec;
    decoded_t          q;
    logic [XLEN_P-1:0] pc_q;
    logic              valid_q;
    logic              uses_rs1;
    logic              uses_rs2;
    logic              load_use;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    imm_gen u_imm_gen (
        .instr (instr),
        .imm   (imm_c)
    );

    // Field decode; illegal encodings are squashed to a harmless ADD with no side effects.
    always_comb begin
        dec          = '0;
        dec.rs1      = instr[19:15];
        dec.rs2      = instr[24:20];
        dec.rd       = instr[11:7];
        dec.imm      = imm_c;
        dec.alu_op   = ALU_ADD_SUB;
        uses_rs1     = 1'b1;
        uses_rs2     = 1'b0;
        case (opcode)
            OPC_OP: begin
                dec.alu_op    = {1'b0, funct3};
                dec.reg_write = 1'b1;
                uses_rs2      = 1'b1;
                if (funct3 == 3'b000 || funct3 == 3'b101) dec.op_choice = funct7[5];
                if (!(funct7 == 7'b0000000 ||
                      (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101))))
                    dec.illegal = 1'b1;
            end
            OPC_OP_IMM: begin
                dec.alu_op    = {1'b0, funct3};
                dec.use_imm   = 1'b1;
                dec.reg_write = 1'b1;
                if (funct3 == 3'b101) dec.op_choice = funct7[5];
                if (funct3 == 3'b001 && funct7 != 7'b0000000) dec.illegal = 1'b1;
            end
            OPC_LUI: begin
                dec.alu_op    = ALU_LUI;
                dec.use_imm   = 1'b1;
                dec.reg_write = 1'b1;
                uses_rs1      = 1'b0;
            end
            OPC_AUIPC: begin
                dec.alu_op    = ALU_AUIPC;
                dec.use_imm   = 1'b1;
                dec.reg_write = 1'b1;
                uses_rs1      = 1'b0;
            end
            OPC_BRANCH: begin
                dec.alu_op    = ALU_AUIPC;
                dec.use_imm   = 1'b1;
                dec.is_branch = 1'b1;
                uses_rs2      = 1'b1;
            end
            OPC_JAL: begin
                dec.alu_op    = ALU_AUIPC;
                dec.use_imm   = 1'b1;
                dec.is_jump   = 1'b1;
                dec.reg_write = 1'b1;
                uses_rs1      = 1'b0;
            end
            OPC_JALR: begin
                dec.use_imm   = 1'b1;
                dec.is_jump   = 1'b1;
                dec.reg_write = 1'b1;
            end
            OPC_LOAD: begin
                dec.use_imm   = 1'b1;
                dec.is_load   = 1'b1;
                dec.reg_write = 1'b1;
            end
            OPC_STORE: begin
                dec.use_imm   = 1'b1;
                dec.is_store  = 1'b1;
                uses_rs2      = 1'b1;
            end
            default: dec.illegal = 1'b1;
        endcase
        if (dec.illegal) begin
            dec.alu_op    = ALU_ADD_SUB;
            dec.use_imm   = 1'b0;
            dec.op_choice = 1'b0;
            dec.reg_write = 1'b0;
            dec.is_load   = 1'b0;
            dec.is_store  = 1'b0;
            dec.is_branch = 1'b0;
            dec.is_jump   = 1'b0;
        end
        if (dec.rd == 5'd0) dec.reg_write = 1'b0;
    end

    // A held load with a live rd blocks any incoming reader of that register.
    assign load_use = valid_q && q.is_load && (q.rd != 5'd0) &&
                      ((uses_rs1 && (dec.rs1 == q.rd)) || (uses_rs2 && (dec.rs2 == q.rd)));

    assign if_ready = (!valid_q || ex_ready) && !load_use && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q       <= '0;
            pc_q    <= '0;
            valid_q <= 1'b0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (if_valid && if_ready) begin
            q       <= dec;
            pc_q    <= if_pc;
            valid_q <= 1'b1;
        end else if (ex_ready && valid_q) begin
            valid_q <= 1'b0;
        end
    end

    assign id_valid  = valid_q;
    assign alu_op    = q.alu_op;
    assign use_imm   = q.use_imm;
    assign op_choice = q.op_choice;
    assign imm       = XLEN_P'(q.imm);
    assign pc        = pc_q;
    assign rs1       = q.rs1;
    assign rs2       = q.rs2;
    assign rd        = q.rd;
    assign reg_write = q.reg_write;
    assign is_load   = q.is_load;
    assign is_store  = q.is_store;
    assign is_branch = q.is_branch;
    assign is_jump   = q.is_jump;
    assign illegal   = q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed plus randomized bench for decode_stage against an instruction-level reference model.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] instr;
    logic [31:0] if_pc;
    logic        flush;
    logic        ex_ready;
    logic        id_valid;
    logic [3:0]  alu_op;
    logic        use_imm;
    logic        op_choice;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [4:0]  rs1, rs2, rd;
    logic        reg_write, is_load, is_store, is_branch, is_jump, illegal;

    int checks = 0;
    int errors = 0;

    decode_stage dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_ready(if_ready), .instr(instr),
        .if_pc(if_pc), .flush(flush), .ex_ready(ex_ready), .id_valid(id_valid),
        .alu_op(alu_op), .use_imm(use_imm), .op_choice(op_choice), .imm(imm), .pc(pc),
        .rs1(rs1), .rs2(rs2), .rd(rd), .reg_write(reg_write), .is_load(is_load),
        .is_store(is_store), .is_branch(is_branch), .is_jump(is_jump), .illegal(illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [3:0]  alu_op;
        logic        use_imm;
        bit          use_imm_def;
        logic        op_choice;
        bit          op_choice_def;
        logic [31:0] imm;
        bit          imm_def;
        logic [4:0]  rs1, rs2, rd;
        logic        reg_write, is_load, is_store, is_branch, is_jump, illegal;
        bit          uses1, uses2;
    } ref_t;

    bit          m_valid;
    ref_t        m_cur;
    logic [31:0] m_pc;

    // Instruction-level model: fields computed with plain arithmetic on the word.
    function automatic ref_t ref_decode(input logic [31:0] w);
        ref_t r;
        int unsigned u, op, f3, f7;
        int sgn_b, sgn_j;
        bit ok;
        u  = w;
        op = u & 127;
        f3 = (u >> 12) & 7;
        f7 = (u >> 25) & 127;
        r = '{default: 0};
        r.rs1 = 5'((u >> 15) & 31);
        r.rs2 = 5'((u >> 20) & 31);
        r.rd  = 5'((u >> 7) & 31);
        sgn_b = w[31] ? -4096 : 0;
        sgn_j = w[31] ? -1048576 : 0;
        ok = 1;
        r.uses1 = !(op == 'h37 || op == 'h17 || op == 'h6F);
        r.uses2 = (op == 'h33 || op == 'h63 || op == 'h23);
        case (op)
            'h33: begin
                ok = (f7 == 0) || (f7 == 32 && (f3 == 0 || f3 == 5));
                r.alu_op = 4'(f3); r.use_imm = 0; r.use_imm_def = 1;
                r.op_choice = (f3 == 0 || f3 == 5) && (f7 == 32); r.op_choice_def = 1;
                r.reg_write = 1;
            end
            'h13: begin
                ok = !(f3 == 1 && f7 != 0);
                r.alu_op = 4'(f3); r.use_imm = 1; r.use_imm_def = 1;
                r.op_choice = (f3 == 5) && ((f7 >> 5) & 1) == 1; r.op_choice_def = 1;
                r.imm = 32'($signed(w) >>> 20); r.imm_def = 1;
                r.reg_write = 1;
            end
            'h37, 'h17: begin
                r.alu_op = (op == 'h37) ? 4'd11 : 4'd10;
                r.imm = w & 32'hFFFFF000; r.imm_def = 1;
                r.reg_write = 1;
            end
            'h63: begin
                r.alu_op = 4'd10; r.is_branch = 1;
                r.imm = 32'(sgn_b + (((u >> 7) & 1) << 11) + (((u >> 25) & 63) << 5)
                            + (((u >> 8) & 15) << 1));
                r.imm_def = 1;
            end
            'h6F: begin
                r.alu_op = 4'd10; r.is_jump = 1; r.reg_write = 1;
                r.imm = 32'(sgn_j + (((u >> 12) & 255) << 12) + (((u >> 20) & 1) << 11)
                            + (((u >> 21) & 1023) << 1));
                r.imm_def = 1;
            end
            'h67, 'h03: begin
                r.alu_op = 0; r.use_imm = 1; r.use_imm_def = 1;
                r.imm = 32'($signed(w) >>> 20); r.imm_def = 1;
                r.reg_write = 1; r.is_jump = (op == 'h67); r.is_load = (op == 'h03);
            end
            'h23: begin
                r.alu_op = 0; r.use_imm = 1; r.use_imm_def = 1; r.is_store = 1;
                r.imm = 32'(($signed(w) >>> 25) * 32) | ((w >> 7) & 32'd31); r.imm_def = 1;
            end
            default: ok = 0;
        endcase
        if (!ok) begin
            r.illegal = 1; r.alu_op = 0; r.reg_write = 0; r.is_load = 0; r.is_store = 0;
            r.is_branch = 0; r.is_jump = 0;
            r.use_imm_def = 0; r.op_choice_def = 0; r.imm_def = 0;
        end
        if (r.rd == 0) r.reg_write = 0;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_outputs();
        chk("id_valid", 32'(id_valid), 32'(m_valid));
        chk("pc", pc, m_pc);
        chk("rs1", 32'(rs1), 32'(m_cur.rs1));
        chk("rs2", 32'(rs2), 32'(m_cur.rs2));
        chk("rd", 32'(rd), 32'(m_cur.rd));
        chk("alu_op", 32'(alu_op), 32'(m_cur.alu_op));
        chk("reg_write", 32'(reg_write), 32'(m_cur.reg_write));
        chk("is_load", 32'(is_load), 32'(m_cur.is_load));
        chk("is_store", 32'(is_store), 32'(m_cur.is_store));
        chk("is_branch", 32'(is_branch), 32'(m_cur.is_branch));
        chk("is_jump", 32'(is_jump), 32'(m_cur.is_jump));
        chk("illegal", 32'(illegal), 32'(m_cur.illegal));
        if (m_cur.use_imm_def) chk("use_imm", 32'(use_imm), 32'(m_cur.use_imm));
        if (m_cur.op_choice_def) chk("op_choice", 32'(op_choice), 32'(m_cur.op_choice));
        if (m_cur.imm_def) chk("imm", imm, m_cur.imm);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_valid"}, 32'(id_valid), 0);
        chk({tag, "_ctrl"}, 32'({alu_op, use_imm, op_choice, reg_write, is_load, is_store,
                                 is_branch, is_jump, illegal}), 0);
        chk({tag, "_imm"}, imm, 0);
        chk({tag, "_pc"}, pc, 0);
        chk({tag, "_regs"}, 32'({rs1, rs2, rd}), 0);
    endtask

    task automatic model_reset();
        m_valid = 0;
        m_cur   = '{default: 0};
        m_pc    = 0;
    endtask

    // One cycle: drive at negedge, check if_ready, clock, advance model, check registers.
    task automatic step(input logic iv, input logic [31:0] w, input logic [31:0] p,
                        input logic er, input logic fl);
        ref_t d;
        bit lu, rdy;
        if_valid = iv; instr = w; if_pc = p; ex_ready = er; flush = fl;
        #1;
        d   = ref_decode(w);
        lu  = m_valid && m_cur.is_load && m_cur.rd != 0 &&
              ((d.uses1 && d.rs1 == m_cur.rd) || (d.uses2 && d.rs2 == m_cur.rd));
        rdy = (!m_valid || er) && !lu && !fl;
        chk("if_ready", 32'(if_ready), 32'(rdy));
        @(posedge clk);
        if (fl) m_valid = 0;
        else if (iv && rdy) begin
            m_cur = d; m_pc = p; m_valid = 1;
        end else if (er && m_valid) m_valid = 0;
        @(negedge clk);
        check_outputs();
    endtask

    function automatic logic [31:0] rand_instr();
        logic [4:0] ra, rb, rdv;
        logic [2:0] f3;
        logic [31:0] r;
        ra  = 5'($urandom_range(0, 3));
        rb  = 5'($urandom_range(0, 3));
        rdv = 5'($urandom_range(0, 3));
        f3  = 3'($urandom);
        r   = $urandom;
        case ($urandom_range(0, 10))
            0: rand_instr = {7'b0000000, rb, ra, f3, rdv, 7'h33};
            1: rand_instr = {($urandom_range(0, 1) == 1) ? 7'b0100000 : 7'($urandom), rb, ra, f3, rdv, 7'h33};
            2: rand_instr = {r[31:20], ra, f3, rdv, 7'h13};
            3: rand_instr = {r[31:12], rdv, 7'h37};
            4: rand_instr = {r[31:12], rdv, 7'h17};
            5: rand_instr = {r[31:25], rb, ra, f3, r[11:7], 7'h63};
            6: rand_instr = {r[31:12], rdv, 7'h6F};
            7: rand_instr = {r[31:20], ra, 3'b000, rdv, 7'h67};
            8: rand_instr = {r[31:20], ra, 3'b010, rdv, 7'h03};
            9: rand_instr = {r[31:25], rb, ra, 3'b010, r[11:7], 7'h23};
            default: rand_instr = r;
        endcase
    endfunction

    initial begin
        rst = 1; if_valid = 0; instr = 0; if_pc = 0; flush = 0; ex_ready = 0;
        model_reset();
        @(negedge clk); @(negedge clk);
        check_all_zero("reset");
        rst = 0;

        step(1, 32'hFFB10093, 32'h0, 1, 0);
        chk("addi_imm", imm, 32'hFFFFFFFB);
        chk("addi_fields", 32'({id_valid, alu_op, use_imm, op_choice, rs1, rd, reg_write}),
            32'({1'b1, 4'b0000, 1'b1, 1'b0, 5'd2, 5'd1, 1'b1}));
        step(1, 32'h402081B3, 32'h4, 1, 0);
        chk("sub_ctrl", 32'({alu_op, op_choice, use_imm}), 32'({4'b0000, 1'b1, 1'b0}));
        step(1, 32'h40335293, 32'h8, 1, 0);
        chk("srai_ctrl", 32'({alu_op, op_choice, imm[4:0]}), 32'({4'b0101, 1'b1, 5'd3}));
        step(1, 32'h123453B7, 32'hC, 1, 0);
        chk("lui", 32'(alu_op), 32'hB);
        chk("lui_imm", imm, 32'h12345000);
        step(1, 32'h00208463, 32'h100, 1, 0);
        chk("beq", 32'({alu_op, is_branch, reg_write}), 32'({4'b1010, 1'b1, 1'b0}));
        chk("beq_imm", imm, 32'h8);
        chk("beq_pc", pc, 32'h100);

        step(1, 32'h00012083, 32'h200, 1, 0);
        step(1, 32'h004081B3, 32'h204, 1, 0);
        chk("load_use_bubble", 32'(id_valid), 0);
        step(1, 32'h004081B3, 32'h204, 1, 0);
        chk("add_after_bubble", 32'({id_valid, rd}), 32'({1'b1, 5'd3}));

        step(1, 32'h00500113, 32'h300, 1, 0);
        for (int i = 0; i < 3; i++) step(1, 32'h00100193, 32'h304, 0, 0);
        chk("stall_pc", pc, 32'h300);
        step(1, 32'h00100193, 32'h304, 1, 1);
        chk("flush_valid", 32'(id_valid), 0);
        chk("flush_pc", pc, 32'h300);

        step(1, 32'h0000007F, 32'h400, 1, 0);
        chk("illegal_op", 32'({id_valid, illegal, reg_write}), 32'({1'b1, 1'b1, 1'b0}));

        for (int i = 0; i < 400; i++)
            step(($urandom_range(0, 9) < 8), rand_instr(), 32'($urandom) & 32'hFFFFFFFC,
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0));

        step(1, 32'h00500113, 32'h500, 0, 0);
        #2 rst = 1;
        #1;
        model_reset();
        check_all_zero("async_rst");
        @(negedge clk);
        rst = 0;
        step(1, 32'h123453B7, 32'h600, 1, 0);
        chk("first_after_rst", 32'(id_valid), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
